inst_fetch: RTL and testbench
=============================

# inst_fetch

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register.
- Owns the PC and runs a one-outstanding request/grant/response handshake with the instruction memory bus.
- Buffers a returned instruction while the pipeline is stalled.
- Presents `if_pc`/`if_inst` to IF/ID and raises `stallreq_if` to ctrl while no instruction is available.
- Applies branch redirects from ID and exception flushes from ctrl.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `stall`  in  8  ctrl stall vector; only `stall[0]` (freeze PC) is used.
- `flush`  in  1  exception flush from ctrl.
- `new_pc`  in  32  flush target.
- `branch_flag`  in  1  ID: branch/jump taken.
- `branch_target`  in  32  ID: branch/jump target.
- `inst_req`  out  1  fetch request, held until granted.
- `inst_addr`  out  32  fetch address (= PC).
- `inst_gnt`  in  1  bus accepted request this cycle.
- `inst_rvalid`  in  1  read data valid; at least 1 cycle after grant.
- `inst_rdata`  in  32  instruction word.
- `if_pc`  out  32  PC of presented instruction.
- `if_inst`  out  32  presented instruction; 0 (nop) when none available.
- `stallreq_if`  out  1  fetch not ready, request pipeline stall.

## Operation
- States: IDLE, FETCH, WAIT, READY, DISCARD.
- `avail` = (WAIT & `inst_rvalid`) | READY.
- `advance` = `avail` & !`stall[0]` & !`flush`.
- IDLE: entered only from reset; `inst_req`=0; unconditional move to FETCH next cycle.
- FETCH: `inst_req`=1, `inst_addr`=PC.
  - On `inst_gnt` -> WAIT; otherwise stay.
- WAIT, `inst_rvalid` & `advance`: `if_inst`=`inst_rdata` (combinational pass-through).
  - PC <= `branch_flag` ? `branch_target` : PC+4; -> FETCH.
- WAIT, `inst_rvalid` & `stall[0]` & !`flush`: capture `inst_rdata` into hold buffer; -> READY; PC unchanged.
- READY: `if_inst`=hold buffer.
  - On `advance`: PC update as above; -> FETCH.
- `stallreq_if` = !`avail`, in every state.
- `if_pc` = PC always. `if_inst` = 0 whenever !`avail`.
- Next-PC arithmetic: 32-bit, PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no alignment check.
- `branch_flag` is sampled only on an `advance` cycle. ID holds it while the pipeline stalls, so the instruction presented on that cycle (the delay slot) still issues.
- Flush has priority over stall, branch and avail:
  - PC <= `new_pc`.
  - If a response is still owed -> DISCARD. A response is owed in FETCH with `inst_gnt`, or in WAIT without `inst_rvalid`.
  - Otherwise -> FETCH.
  - Hold buffer is invalidated.
- DISCARD: `inst_req`=0, `stallreq_if`=1; drop data on `inst_rvalid` and -> FETCH.
  - A further `flush` in DISCARD updates PC only; state stays DISCARD.
- `stall[0]` in FETCH does not suppress the request.
- Never more than one request outstanding.

## Timing
- Reset (`rst`=0, async): PC=`RESET_PC`, state IDLE, hold buffer=0.
  - Outputs during reset: `inst_req`=0, `inst_addr`=`RESET_PC`, `if_pc`=`RESET_PC`, `if_inst`=0, `stallreq_if`=1.
- Reset asserted mid-transaction abandons it. The bus must not return a response after reset.
- First `inst_req` appears 1 cycle after reset release (IDLE -> FETCH).
- Best case: grant in FETCH cycle, `inst_rvalid` next cycle. That gives 2 cycles/instruction, with the instruction visible in the `inst_rvalid` cycle.
- Buffered instruction advances the cycle `stall[0]` drops; the next request issues the following cycle.
- Flush takes effect at the next edge; the request for `new_pc` issues the cycle after that, or after the owed response is drained.

## Test plan
- Reset release, bus grants immediately with `inst_rvalid` 1 cycle later, RESET_PC=0:
  - requests go to 0x0, 0x4, 0x8 on alternate cycles.
  - `if_inst` matches the returned data with `if_pc` 0,4,8.
  - `stallreq_if` is 0 only on `inst_rvalid` cycles.
- `stall[0]`=1 for 3 cycles spanning an `inst_rvalid` of 32'h2402_0005 at PC 0x10:
  - state goes to READY, `if_inst` holds 32'h2402_0005, `stallreq_if`=0.
  - after release, PC goes to 0x14 and the next request is 0x14.
- Branch: at `advance` with PC=0x20, `branch_flag`=1, `branch_target`=0x100:
  - the 0x20 instruction is presented.
  - next request address is 0x100 (not 0x24).
- Flush while WAIT at PC 0x40 (granted, no data), `new_pc`=0x180:
  - state goes to DISCARD, `stallreq_if`=1.
  - late data 32'hDEAD_BEEF never appears on `if_inst`.
  - next request address is 0x180.
- Flush in the same cycle as `inst_rvalid`: the data is dropped and the next request is `new_pc` with no DISCARD state.
- PC=32'hFFFF_FFFC advances -> next request to 0x0. Async reset asserted in WAIT -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, runs a one-outstanding req/gnt/rvalid handshake with the
// instruction bus, buffers a returned word while the pipeline is stalled,
// and applies ID branch redirects and ctrl exception flushes.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   stall[7:0]        ctrl stall vector (only stall[0] = freeze PC is used)
//   flush, new_pc     exception flush and its target
//   branch_flag/target  taken branch/jump from ID, sampled on advance
//   inst_req/addr     fetch request (held until granted) and address (= PC)
//   inst_gnt          bus accepted the request
//   inst_rvalid/rdata returned instruction word
//   if_pc/if_inst     PC and instruction presented to IF/ID (nop when none)
//   stallreq_if       no instruction available; stall the pipeline
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_gnt,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_READY,
        S_DISCARD
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic [XLEN-1:0]   hold, hold_nxt;
    logic [XLEN-1:0]   pc_seq;
    logic              avail;
    logic              advance;

    // Only the PC-freeze bit of the stall vector matters to fetch.
    logic              stall_unused;
    assign stall_unused = ^stall[7:1];

    // State, PC and hold-buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            hold  <= hold_nxt;
        end
    end

    // Next-state, next-PC and output logic.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        hold_nxt    = hold;

        avail       = ((state == S_WAIT) && inst_rvalid) || (state == S_READY);
        advance     = avail && !stall[0] && !flush;
        // Branch is only honoured on an advance, so the presented word
        // (delay slot) always issues before the redirect.
        pc_seq      = branch_flag ? branch_target : pc + XLEN'(4);

        inst_req    = (state == S_FETCH);
        inst_addr   = pc;
        if_pc       = pc;
        stallreq_if = !avail;
        if_inst     = '0;
        if (avail) begin
            if_inst = (state == S_READY) ? hold : inst_rdata;
        end

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (flush) begin
                    pc_nxt    = new_pc;
                    // A grant this cycle means a response is still owed.
                    state_nxt = inst_gnt ? S_DISCARD : S_FETCH;
                end else if (inst_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_nxt    = new_pc;
                    hold_nxt  = '0;
                    state_nxt = inst_rvalid ? S_FETCH : S_DISCARD;
                end else if (inst_rvalid) begin
                    if (advance) begin
                        pc_nxt    = pc_seq;
                        state_nxt = S_FETCH;
                    end else begin
                        hold_nxt  = inst_rdata;
                        state_nxt = S_READY;
                    end
                end
            end
            S_READY: begin
                if (flush) begin
                    pc_nxt    = new_pc;
                    hold_nxt  = '0;
                    state_nxt = S_FETCH;
                end else if (advance) begin
                    pc_nxt    = pc_seq;
                    state_nxt = S_FETCH;
                end
            end
            S_DISCARD: begin
                // Drain the owed response; later flushes only retarget PC.
                if (flush) begin
                    pc_nxt = new_pc;
                end
                if (inst_rvalid) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: in-order fetch, stall buffering, branch
// redirect, flush with and without an owed response, PC wrap, async reset.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int vectors = 0;
    int errors  = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_gnt     (inst_gnt),
        .inst_rvalid  (inst_rvalid),
        .inst_rdata   (inst_rdata),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .stallreq_if  (stallreq_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled in the low phase.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // FETCH with immediate grant, then rvalid next cycle with no stall.
    task automatic fetch_simple(input logic [31:0] exp_pc, input logic [31:0] data);
        inst_gnt = 1'b1;
        #1;
        check("req",        32'(inst_req), 32'd1);
        check("addr",       inst_addr, exp_pc);
        check("stall_fetch", 32'(stallreq_if), 32'd1);
        check("inst_nop",   if_inst, 32'h0);
        tick();
        inst_gnt    = 1'b0;
        inst_rvalid = 1'b1;
        inst_rdata  = data;
        #1;
        check("inst",       if_inst, data);
        check("pc",         if_pc, exp_pc);
        check("stall_rv",   32'(stallreq_if), 32'd0);
        check("req_wait",   32'(inst_req), 32'd0);
        tick();
        inst_rvalid = 1'b0;
        inst_rdata  = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag = 1'b0; branch_target = '0;
        inst_gnt = 1'b0; inst_rvalid = 1'b0; inst_rdata = '0;

        // Reset values.
        @(negedge clk);
        #1;
        check("rst_req",   32'(inst_req), 32'd0);
        check("rst_addr",  inst_addr, 32'h0);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_inst",  if_inst, 32'h0);
        check("rst_stall", 32'(stallreq_if), 32'd1);
        rst = 1'b1;
        #1;
        check("idle_req",  32'(inst_req), 32'd0);
        tick();

        // Back-to-back fetches at 0,4,8,C.
        fetch_simple(32'h0, 32'h2001_0001);
        fetch_simple(32'h4, 32'h2002_0002);
        fetch_simple(32'h8, 32'h2003_0003);
        fetch_simple(32'hC, 32'h2004_0004);

        // Stall spanning rvalid at 0x10.
        inst_gnt = 1'b1;
        #1 check("req10", inst_addr, 32'h10);
        tick();
        inst_gnt = 1'b0; stall = 8'h01;
        inst_rvalid = 1'b1; inst_rdata = 32'h2402_0005;
        #1 check("st_rv_inst", if_inst, 32'h2402_0005);
        check("st_rv_stall", 32'(stallreq_if), 32'd0);
        tick();
        inst_rvalid = 1'b0; inst_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("hold_inst",  if_inst, 32'h2402_0005);
            check("hold_stall", 32'(stallreq_if), 32'd0);
            check("hold_req",   32'(inst_req), 32'd0);
            check("hold_pc",    if_pc, 32'h10);
            tick();
        end
        stall = 8'h00;
        #1 check("rel_inst", if_inst, 32'h2402_0005);
        tick();
        // Stall in FETCH must not suppress the request.
        stall = 8'h01;
        #1 check("st_fetch_req", 32'(inst_req), 32'd1);
        check("st_fetch_addr", inst_addr, 32'h14);
        tick();
        stall = 8'h00;

        fetch_simple(32'h14, 32'h2005_0005);
        fetch_simple(32'h18, 32'h2006_0006);
        fetch_simple(32'h1C, 32'h2007_0007);

        // Branch at 0x20 -> 0x100; delay-slot word still presented.
        branch_flag = 1'b1; branch_target = 32'h100;
        fetch_simple(32'h20, 32'h1000_0040);
        branch_flag = 1'b0;
        #1 check("br_addr", inst_addr, 32'h100);
        fetch_simple(32'h100, 32'h2008_0008);
        branch_flag = 1'b1; branch_target = 32'h40;
        fetch_simple(32'h104, 32'h2009_0009);
        branch_flag = 1'b0;

        // Flush in WAIT at 0x40 with response owed.
        inst_gnt = 1'b1;
        #1 check("req40", inst_addr, 32'h40);
        tick();
        inst_gnt = 1'b0; flush = 1'b1; new_pc = 32'h180;
        #1 check("fl_stall", 32'(stallreq_if), 32'd1);
        tick();
        flush = 1'b0;
        #1 check("dis_req",   32'(inst_req), 32'd0);
        check("dis_stall",    32'(stallreq_if), 32'd1);
        check("dis_pc",       if_pc, 32'h180);
        tick();
        inst_rvalid = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        #1 check("dis_inst",  if_inst, 32'h0);
        check("dis_stall2",   32'(stallreq_if), 32'd1);
        tick();
        inst_rvalid = 1'b0; inst_rdata = '0;
        #1 check("fl_req",    32'(inst_req), 32'd1);
        check("fl_addr",      inst_addr, 32'h180);

        // Flush in the rvalid cycle: no DISCARD.
        inst_gnt = 1'b1;
        tick();
        inst_gnt = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'h1111_1111;
        flush = 1'b1; new_pc = 32'h200;
        tick();
        flush = 1'b0; inst_rvalid = 1'b0;
        #1 check("flrv_req",  32'(inst_req), 32'd1);
        check("flrv_addr",    inst_addr, 32'h200);

        // Flush in FETCH without grant, to the wrap address.
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        fetch_simple(32'hFFFF_FFFC, 32'h200A_000A);
        #1 check("wrap_addr", inst_addr, 32'h0);
        check("wrap_req",     32'(inst_req), 32'd1);

        // Async reset while in WAIT at 0x4.
        fetch_simple(32'h0, 32'h200B_000B);
        inst_gnt = 1'b1;
        tick();
        inst_gnt = 1'b0;
        #1 check("pre_rst_pc", if_pc, 32'h4);
        rst = 1'b0;
        #1;
        check("arst_req",   32'(inst_req), 32'd0);
        check("arst_addr",  inst_addr, 32'h0);
        check("arst_pc",    if_pc, 32'h0);
        check("arst_inst",  if_inst, 32'h0);
        check("arst_stall", 32'(stallreq_if), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
